// File: rtl/spi_resp_buffered.sv
// spi_resp_buffered
//   SPI mode-0 responder (MSB first, full duplex) with show-ahead TX and RX
//   FIFOs. All SPI inputs are oversampled by Clk_i through 2-flop synchronisers.
// Ports
//   Clk_i, Rst_ni            system clock, asynchronous active-low reset
//   Sclk_i, Mosi_i, Ss_i     SPI inputs from the master (Ss_i[ID] selects us)
//   Miso_o, MisoEn_o         MISO data and its tri-state drive enable
//   toXmit_i, strobe_i       TX FIFO push port; XmitFull_o / XmitEmpty_o status
//   Rcvd_o, Ready_o, pop_i   RX FIFO head, not-empty flag and pop
//   busy_o                   frame in progress
//   ovr_o, udr_o, clr_i      sticky RX overrun / TX underrun flags and clear
module spi_resp_buffered #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ID    = 0,
    parameter int NSS   = 2
) (
    input  logic             Clk_i,
    input  logic             Rst_ni,
    input  logic             Sclk_i,
    input  logic             Mosi_i,
    input  logic [NSS-1:0]   Ss_i,
    output logic             Miso_o,
    output logic             MisoEn_o,
    input  logic [WIDTH-1:0] toXmit_i,
    input  logic             strobe_i,
    output logic             XmitFull_o,
    output logic             XmitEmpty_o,
    output logic [WIDTH-1:0] Rcvd_o,
    output logic             Ready_o,
    input  logic             pop_i,
    output logic             busy_o,
    output logic             ovr_o,
    output logic             udr_o,
    input  logic             clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_sync_q, sclk_sync_d;
    logic [1:0]       mosi_sync_q, mosi_sync_d;
    logic [2:0]       ss_sync_q, ss_sync_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             miso_q, miso_d;
    logic             loaded_q, loaded_d;
    logic             ovr_q, ovr_d;
    logic             udr_q, udr_d;
    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [WIDTH-1:0] tx_mem_d [DEPTH];
    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [WIDTH-1:0] rx_mem_d [DEPTH];
    logic [PW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

    logic             sclk_rise, sclk_fall, ss_rise, ss_lvl;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic [PW-1:0]    tx_cnt;
    logic             done, load, tx_pop, tx_push, rx_push, rx_pop;
    logic             nxt_avail;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] load_data;
    logic             unused_ss;

    assign unused_ss = ^Ss_i;

    assign sclk_sync_d = {sclk_sync_q[1:0], Sclk_i};
    assign mosi_sync_d = {mosi_sync_q[0], Mosi_i};
    assign ss_sync_d   = {ss_sync_q[1:0], Ss_i[ID]};

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_lvl    = ss_sync_q[1];

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign tx_cnt   = tx_wr_q - tx_rd_q;

    assign done    = (state_q == DONE);
    assign load    = ((state_q == IDLE) && ss_rise) || (done && ss_lvl);
    assign tx_pop  = done && loaded_q;
    assign tx_push = strobe_i && !tx_full;
    assign rx_push = done && !rx_full;
    assign rx_pop  = pop_i && !rx_empty;

    // A back-to-back reload happens in the same cycle the old head is popped,
    // so it must take the entry behind the head; a same-cycle push is not seen.
    assign nxt_avail = tx_pop ? (tx_cnt > PW'(1)) : !tx_empty;
    assign nxt_idx   = tx_pop ? (tx_rd_q[AW-1:0] + AW'(1)) : tx_rd_q[AW-1:0];
    assign load_data = nxt_avail ? tx_mem_q[nxt_idx] : '0;

    // The SS synchroniser resets high so that a reset released while SS is
    // still asserted does not look like a new frame start.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            cnt_q       <= '0;
            shreg_q     <= '0;
            miso_q      <= 1'b0;
            loaded_q    <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
            tx_mem_q    <= '{default: '0};
            rx_mem_q    <= '{default: '0};
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            miso_q      <= miso_d;
            loaded_q    <= loaded_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
            tx_mem_q    <= tx_mem_d;
            rx_mem_q    <= rx_mem_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
        end
    end

    // Frame completion takes priority over SS dropping in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_rise) state_d = ACTIVE;
            ACTIVE:  if (cnt_q == CW'(WIDTH)) state_d = DONE;
                     else if (!ss_lvl)        state_d = IDLE;
            DONE:    state_d = ss_lvl ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MISO is held in its own flop so it only moves on SCLK falling edges,
    // while the shift register itself shifts on rising edges.
    always_comb begin
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        miso_d   = miso_q;
        loaded_d = loaded_q;
        ovr_d    = ovr_q;
        udr_d    = udr_q;
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;

        if (clr_i) begin
            ovr_d = 1'b0;
            udr_d = 1'b0;
        end

        if (load) begin
            shreg_d  = load_data;
            miso_d   = load_data[WIDTH-1];
            cnt_d    = '0;
            loaded_d = nxt_avail;
            if (!nxt_avail) udr_d = 1'b1;
        end else if (state_q == ACTIVE) begin
            if (sclk_rise) begin
                shreg_d = {shreg_q[WIDTH-2:0], mosi_sync_q[1]};
                cnt_d   = cnt_q + CW'(1);
            end
            if (sclk_fall) miso_d = shreg_q[WIDTH-1];
        end

        if (done && rx_full) ovr_d = 1'b1;

        if (tx_push) begin
            tx_mem_d[tx_wr_q[AW-1:0]] = toXmit_i;
            tx_wr_d = tx_wr_q + PW'(1);
        end
        if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);

        if (rx_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = shreg_q;
            rx_wr_d = rx_wr_q + PW'(1);
        end
        if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);
    end

    assign Miso_o      = miso_q;
    assign MisoEn_o    = (state_q != IDLE);
    assign busy_o      = (state_q != IDLE);
    assign XmitFull_o  = tx_full;
    assign XmitEmpty_o = tx_empty;
    assign Rcvd_o      = rx_mem_q[rx_rd_q[AW-1:0]];
    assign Ready_o     = !rx_empty;
    assign ovr_o       = ovr_q;
    assign udr_o       = udr_q;

endmodule

// File: tb/tb_spi_resp_buffered.sv
// tb_spi_resp_buffered
//   Directed scenarios with literal expectations, then random host/SPI
//   traffic checked against a queue-based model of the responder.
module tb_spi_resp_buffered;
    localparam int H = 5;   // SCLK half period in Clk_i cycles

    logic       Clk_i = 1'b0;
    logic       Rst_ni = 1'b0;
    logic       Sclk_i = 1'b0;
    logic       Mosi_i = 1'b0;
    logic [1:0] Ss_i = '0;
    logic       Miso_o, MisoEn_o;
    logic [7:0] toXmit_i = '0;
    logic       strobe_i = 1'b0;
    logic       XmitFull_o, XmitEmpty_o;
    logic [7:0] Rcvd_o;
    logic       Ready_o;
    logic       pop_i = 1'b0;
    logic       busy_o, ovr_o, udr_o;
    logic       clr_i = 1'b0;

    spi_resp_buffered #(.WIDTH(8), .DEPTH(4), .ID(0), .NSS(2)) dut (
        .Clk_i(Clk_i), .Rst_ni(Rst_ni), .Sclk_i(Sclk_i), .Mosi_i(Mosi_i),
        .Ss_i(Ss_i), .Miso_o(Miso_o), .MisoEn_o(MisoEn_o),
        .toXmit_i(toXmit_i), .strobe_i(strobe_i),
        .XmitFull_o(XmitFull_o), .XmitEmpty_o(XmitEmpty_o),
        .Rcvd_o(Rcvd_o), .Ready_o(Ready_o), .pop_i(pop_i),
        .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o), .clr_i(clr_i)
    );

    always #5 Clk_i = ~Clk_i;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: plain byte queues plus the two sticky flags.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit m_ovr = 1'b0;
    bit m_udr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk_i) begin
        if (chk_en) begin
            chk("xmit_full", XmitFull_o, tx_q.size() == 4);
            chk("xmit_empty", XmitEmpty_o, tx_q.size() == 0);
            chk("ready", Ready_o, rx_q.size() != 0);
            if (rx_q.size() != 0) chk("rcvd", Rcvd_o, rx_q[0]);
            chk("ovr", ovr_o, m_ovr);
            chk("udr", udr_o, m_udr);
            chk("busy_idle", busy_o, 0);
            chk("misoen_idle", MisoEn_o, 0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        chk_en = 1'b0;
        toXmit_i = b;
        strobe_i = 1'b1;
        if (tx_q.size() < 4) tx_q.push_back(b);
        wait_cyc(1);
        strobe_i = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic pop();
        chk_en = 1'b0;
        pop_i = 1'b1;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        wait_cyc(1);
        pop_i = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic clr();
        chk_en = 1'b0;
        clr_i = 1'b1;
        m_ovr = 1'b0;
        m_udr = 1'b0;
        wait_cyc(1);
        clr_i = 1'b0;
        chk_en = 1'b1;
    endtask

    // What the responder will send for a frame that starts now.
    task automatic m_load(output logic [7:0] d, output bit loaded);
        loaded = (tx_q.size() != 0);
        if (loaded) d = tx_q[0];
        else begin
            d = 8'h00;
            m_udr = 1'b1;
        end
    endtask

    task automatic m_done(input logic [7:0] mo, input bit loaded);
        if (loaded) void'(tx_q.pop_front());
        if (rx_q.size() < 4) rx_q.push_back(mo);
        else m_ovr = 1'b1;
    endtask

    // Master side: MOSI changes after SCLK falls, MISO sampled at the rise.
    // With drop set, SS is released just after the last rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int nb, input bit en,
                            input bit drop, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            Mosi_i = mo[7-i];
            wait_cyc(H);
            chk("misoen_frame", MisoEn_o, en);
            chk("busy_frame", busy_o, en);
            mi[7-i] = Miso_o;
            Sclk_i = 1'b1;
            if (drop && i == nb - 1) begin
                wait_cyc(1);
                Ss_i = '0;
                wait_cyc(H - 1);
                Sclk_i = 1'b0;
                wait_cyc(6);
            end else begin
                wait_cyc(H);
                Sclk_i = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] ss, input logic [7:0] mo, input bit first,
                             input bit last, output logic [7:0] mi);
        logic [7:0] exp;
        bit loaded;
        chk_en = 1'b0;
        if (first) begin
            Ss_i = ss;
            wait_cyc(6);
        end
        exp = 8'h00;
        loaded = 1'b0;
        if (ss[0]) m_load(exp, loaded);
        spi_bits(mo, 8, ss[0], last, mi);
        if (ss[0]) begin
            chk("miso_byte", mi, exp);
            m_done(mo, loaded);
        end
        if (last) chk_en = 1'b1;
    endtask

    task automatic abort_frame(input logic [7:0] mo, input int nb, output logic [7:0] mi);
        logic [7:0] exp;
        bit loaded;
        chk_en = 1'b0;
        Ss_i = 2'b01;
        wait_cyc(6);
        m_load(exp, loaded);
        spi_bits(mo, nb, 1'b1, 1'b0, mi);
        wait_cyc(H);
        Ss_i = '0;
        wait_cyc(6);
        chk("abort_bits", mi >> (8 - nb), exp >> (8 - nb));
        chk_en = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, Miso_o, 0);
        chk({tag, "_misoen"}, MisoEn_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ready"}, Ready_o, 0);
        chk({tag, "_rcvd"}, Rcvd_o, 0);
        chk({tag, "_full"}, XmitFull_o, 0);
        chk({tag, "_empty"}, XmitEmpty_o, 1);
        chk({tag, "_ovr"}, ovr_o, 0);
        chk({tag, "_udr"}, udr_o, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] mi;
    logic [7:0] lit_tx [4];
    int r, n, nb;
    logic [1:0] ss;

    initial begin
        lit_tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        wait_cyc(3);
        chk_reset_vals("rst");
        Rst_ni = 1'b1;
        wait_cyc(2);
        chk_en = 1'b1;

        // single exchange
        push(8'hA5);
        run_frame(2'b01, 8'h3C, 1'b1, 1'b1, mi);
        chk("t1_miso", mi, 8'hA5);
        chk("t1_ready", Ready_o, 1);
        chk("t1_rcvd", Rcvd_o, 8'h3C);
        chk("t1_txempty", XmitEmpty_o, 1);
        pop();
        chk("t1_ready_pop", Ready_o, 0);

        // queue and drain, back-to-back frames under one SS
        for (int k = 0; k < 4; k++) push(lit_tx[k]);
        chk("t2_full", XmitFull_o, 1);
        push(8'h55);
        chk("t2_full_after_5th", XmitFull_o, 1);
        for (int k = 0; k < 4; k++) begin
            run_frame(2'b01, 8'(k + 1), k == 0, k == 3, mi);
            chk("t2_miso", mi, lit_tx[k]);
        end
        chk("t2_txempty", XmitEmpty_o, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t2_rcvd", Rcvd_o, k + 1);
            pop();
        end
        chk("t2_ready_drained", Ready_o, 0);

        // underrun, then overrun
        chk("t3_udr_pre", udr_o, 0);
        for (int k = 0; k < 5; k++) begin
            run_frame(2'b01, 8'(8'hE1 + k), 1'b1, 1'b1, mi);
            chk("t3_miso_zero", mi, 8'h00);
            if (k == 0) chk("t3_udr", udr_o, 1);
        end
        chk("t3_ovr", ovr_o, 1);
        chk("t3_head", Rcvd_o, 8'hE1);
        clr();
        chk("t3_ovr_clr", ovr_o, 0);
        chk("t3_udr_clr", udr_o, 0);
        for (int k = 0; k < 4; k++) pop();

        // abort mid-frame, head is resent
        push(8'h96);
        abort_frame(8'hF0, 4, mi);
        chk("t4_abort_nibble", mi >> 4, 4'h9);
        chk("t4_busy", busy_o, 0);
        chk("t4_ready", Ready_o, 0);
        chk("t4_txempty", XmitEmpty_o, 0);
        run_frame(2'b01, 8'h0F, 1'b1, 1'b1, mi);
        chk("t4_resend", mi, 8'h96);
        pop();

        // deselected
        push(8'h5A);
        run_frame(2'b10, 8'hFF, 1'b1, 1'b1, mi);
        chk("t5_ready", Ready_o, 0);
        chk("t5_txempty", XmitEmpty_o, 0);
        run_frame(2'b01, 8'h24, 1'b1, 1'b1, mi);
        chk("t5_miso", mi, 8'h5A);
        pop();

        // reset mid-frame
        push(8'h77);
        chk_en = 1'b0;
        Ss_i = 2'b01;
        wait_cyc(6);
        spi_bits(8'hAB, 3, 1'b1, 1'b0, mi);
        Rst_ni = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tx_q.delete();
        rx_q.delete();
        m_ovr = 1'b0;
        m_udr = 1'b0;
        wait_cyc(2);
        Rst_ni = 1'b1;
        spi_bits(8'hAB << 3, 5, 1'b0, 1'b1, mi);
        chk_en = 1'b1;
        push(8'hC3);
        run_frame(2'b01, 8'h18, 1'b1, 1'b1, mi);
        chk("t6_miso", mi, 8'hC3);
        chk("t6_rcvd", Rcvd_o, 8'h18);
        pop();

        // random traffic
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 19);
            if (r < 6) push(8'($urandom_range(0, 255)));
            else if (r < 10) pop();
            else if (r < 15) begin
                n = $urandom_range(1, 3);
                ss = {1'($urandom_range(0, 1)), 1'b1};
                for (int k = 0; k < n; k++)
                    run_frame(ss, 8'($urandom_range(0, 255)), k == 0, k == n - 1, mi);
            end else if (r < 17) begin
                nb = $urandom_range(1, 7);
                abort_frame(8'($urandom_range(0, 255)), nb, mi);
            end else if (r < 19) run_frame(2'b10, 8'($urandom_range(0, 255)), 1'b1, 1'b1, mi);
            else clr();
            wait_cyc($urandom_range(0, 3));
        end

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
